// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the acquisition-path FIFOs.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : read-mode selector values for FWFT
//   clogb2(value)                   : ceiling log2, used for address widths
//   countWidth(depth)               : width needed to hold 0..depth
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Ceiling log2: the number of address bits needed to index 'value' entries.
   function automatic int clogb2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // A count of 0..depth needs one bit more than the address, which is also
   // the width of the wrap-extended read/write pointers.
   function automatic int countWidth(input int depth);
      return clogb2(depth) + 1;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// ---------------------------------------------------------------------------
// sdp_ram
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port. Deliberately has no reset so it maps onto
// distributed RAM.
//   clock  : write clock
//   wrEn   : write enable
//   wrAddr : write address
//   wrData : write data
//   rdAddr : read address
//   rdData : read data, combinational from rdAddr
// ---------------------------------------------------------------------------
module sdp_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   localparam int AW   = clogb2(DEPTH)
) (
   input  logic             clock,
   input  logic             wrEn,
   input  logic [AW-1:0]    wrAddr,
   input  logic [WIDTH-1:0] wrData,
   input  logic [AW-1:0]    rdAddr,
   output logic [WIDTH-1:0] rdData
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: a single enabled write per clock, no reset on the contents
   // so the array stays inferable as RAM.
   always_ff @(posedge clock) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   // Read port is asynchronous so the FIFO head can fall through without
   // an extra pipeline stage.
   assign rdData = mem[rdAddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock FIFO between the ADC framing logic and the packetisers.
// All DEPTH entries are usable; read mode is first-word-fall-through
// (FWFT=1) or registered standard read (FWFT=0).
//   CLK                : clock, everything on the rising edge
//   RESET              : synchronous active-high reset
//   DIN / WE           : write data / write request
//   FULL               : DEPTH entries stored
//   DOUT / RE          : read data / read request (pop)
//   NOT_EMPTY          : at least one entry stored
//   DATA_COUNT         : exact number of stored entries, 0..DEPTH
//   PROG_FULL_THRE     : almost-full threshold, may change at any time
//   PROG_EMPTY_THRE    : almost-empty threshold, may change at any time
//   PROGRAMMABLE_FULL  : DATA_COUNT >= PROG_FULL_THRE
//   PROGRAMMABLE_EMPTY : DATA_COUNT <= PROG_EMPTY_THRE
//   OVERFLOW           : one-cycle pulse after a rejected write
//   UNDERFLOW          : one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int               WIDTH      = 16,
   parameter int               DEPTH      = 32,
   parameter int               FWFT       = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b1}},
   localparam int              CW         = countWidth(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DIN,
   input  logic             WE,
   output logic             FULL,
   output logic [WIDTH-1:0] DOUT,
   input  logic             RE,
   output logic             NOT_EMPTY,
   output logic [CW-1:0]    DATA_COUNT,
   input  logic [CW-1:0]    PROG_FULL_THRE,
   input  logic [CW-1:0]    PROG_EMPTY_THRE,
   output logic             PROGRAMMABLE_FULL,
   output logic             PROGRAMMABLE_EMPTY,
   output logic             OVERFLOW,
   output logic             UNDERFLOW
);

   localparam int AW = CW - 1;

   logic [CW-1:0]    wrPtr;
   logic [CW-1:0]    rdPtr;
   logic [CW-1:0]    wrPtrNext;
   logic [CW-1:0]    rdPtrNext;
   logic [CW-1:0]    countNext;
   logic             fullNext;
   logic             notEmptyNext;
   logic             writeAccept;
   logic             readAccept;
   logic [WIDTH-1:0] ramRdData;

   // Requests are qualified against the registered flags only, so a full
   // FIFO still accepts a read while rejecting a simultaneous write, and an
   // empty FIFO accepts a write while rejecting a simultaneous read.
   assign writeAccept = WE && !FULL;
   assign readAccept  = RE && NOT_EMPTY;

   // Pointers carry one extra wrap bit, so the next flags and count fall out
   // of the next pointer pair directly. Registering these makes FULL,
   // NOT_EMPTY and DATA_COUNT exact one cycle after the causing edge, with
   // no early-full margin.
   always_comb begin
      wrPtrNext    = wrPtr + {{(CW-1){1'b0}}, writeAccept};
      rdPtrNext    = rdPtr + {{(CW-1){1'b0}}, readAccept};
      countNext    = wrPtrNext - rdPtrNext;
      fullNext     = (wrPtrNext[CW-1] != rdPtrNext[CW-1]) &&
                     (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]);
      notEmptyNext = (wrPtrNext != rdPtrNext);
   end

   // Pointer, flag, count and error-pulse registers. The error pulses are
   // recomputed every cycle so they never stick.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         DATA_COUNT <= '0;
         FULL       <= 1'b0;
         NOT_EMPTY  <= 1'b0;
         OVERFLOW   <= 1'b0;
         UNDERFLOW  <= 1'b0;
      end else begin
         wrPtr      <= wrPtrNext;
         rdPtr      <= rdPtrNext;
         DATA_COUNT <= countNext;
         FULL       <= fullNext;
         NOT_EMPTY  <= notEmptyNext;
         OVERFLOW   <= WE && FULL;
         UNDERFLOW  <= RE && !NOT_EMPTY;
      end
   end

   // Almost-full/almost-empty compare the registered count against the live
   // thresholds, so a threshold change shows up in the same cycle.
   always_comb begin
      PROGRAMMABLE_FULL  = (DATA_COUNT >= PROG_FULL_THRE);
      PROGRAMMABLE_EMPTY = (DATA_COUNT <= PROG_EMPTY_THRE);
   end

   sdp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) uRam (
      .clock  (CLK),
      .wrEn   (writeAccept),
      .wrAddr (wrPtr[AW-1:0]),
      .wrData (DIN),
      .rdAddr (rdPtr[AW-1:0]),
      .rdData (ramRdData)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : gFwft
         // The head word is presented as soon as it is stored; while empty
         // the output is forced to INIT_VALUE, which also keeps the
         // never-written RAM contents (X in simulation) off the port.
         assign DOUT = NOT_EMPTY ? ramRdData : INIT_VALUE;
      end else begin : gStd
         logic [WIDTH-1:0] doutReg;

         // Standard read: an accepted pop captures the head word into the
         // output register; the value holds through idle and rejected reads.
         always_ff @(posedge CLK) begin
            if (RESET) begin
               doutReg <= INIT_VALUE;
            end else if (readAccept) begin
               doutReg <= ramRdData;
            end
         end

         assign DOUT = doutReg;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
// Drives one FWFT and one standard-read instance of sync_fifo_fwft with the
// same stimulus and checks both against a queue-based model every cycle,
// plus literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

   localparam int WIDTH = 16;
   localparam int DEPTH = 32;
   localparam int CW    = 6;
   localparam logic [WIDTH-1:0] INIT = 16'hFFFF;

   logic             CLK;
   logic             RESET;
   logic [WIDTH-1:0] din;
   logic             we;
   logic             re;
   logic [CW-1:0]    progFullThre;
   logic [CW-1:0]    progEmptyThre;

   logic             fFull, fNotEmpty, fProgFull, fProgEmpty, fOvf, fUdf;
   logic [WIDTH-1:0] fDout;
   logic [CW-1:0]    fCount;
   logic             sFull, sNotEmpty, sProgFull, sProgEmpty, sOvf, sUdf;
   logic [WIDTH-1:0] sDout;
   logic [CW-1:0]    sCount;

   int nChecks = 0;
   int nErrors = 0;
   bit checkEn = 1'b0;

   // Model state: queue contents, the standard-read output register and the
   // error pulses produced by the previous edge.
   logic [WIDTH-1:0] modelQ [$];
   logic [WIDTH-1:0] modelStdDout;
   bit               modelOvf;
   bit               modelUdf;

   sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .INIT_VALUE(INIT)) dutFwft (
      .CLK (CLK), .RESET (RESET), .DIN (din), .WE (we), .FULL (fFull), .DOUT (fDout),
      .RE (re), .NOT_EMPTY (fNotEmpty), .DATA_COUNT (fCount),
      .PROG_FULL_THRE (progFullThre), .PROG_EMPTY_THRE (progEmptyThre),
      .PROGRAMMABLE_FULL (fProgFull), .PROGRAMMABLE_EMPTY (fProgEmpty),
      .OVERFLOW (fOvf), .UNDERFLOW (fUdf)
   );

   sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .INIT_VALUE(INIT)) dutStd (
      .CLK (CLK), .RESET (RESET), .DIN (din), .WE (we), .FULL (sFull), .DOUT (sDout),
      .RE (re), .NOT_EMPTY (sNotEmpty), .DATA_COUNT (sCount),
      .PROG_FULL_THRE (progFullThre), .PROG_EMPTY_THRE (progEmptyThre),
      .PROGRAMMABLE_FULL (sProgFull), .PROGRAMMABLE_EMPTY (sProgEmpty),
      .OVERFLOW (sOvf), .UNDERFLOW (sUdf)
   );

   // 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Present one set of inputs for exactly one rising edge; returns 2 ns
   // after that edge, when the registered outputs have settled.
   task automatic applyStimulus(input bit rst, input bit w, input bit r,
                                input logic [WIDTH-1:0] d);
      RESET = rst;
      we    = w;
      re    = r;
      din   = d;
      @(posedge CLK);
      #2;
   endtask

   // Behavioural model: acceptance is decided from the occupancy before the
   // edge, a read is served before the write is appended.
   always @(posedge CLK) begin
      bit wAcc;
      bit rAcc;
      if (RESET) begin
         modelQ.delete();
         modelStdDout = INIT;
         modelOvf     = 1'b0;
         modelUdf     = 1'b0;
      end else begin
         wAcc     = we && (modelQ.size() < DEPTH);
         rAcc     = re && (modelQ.size() > 0);
         modelOvf = we && !wAcc;
         modelUdf = re && !rAcc;
         if (rAcc) begin
            modelStdDout = modelQ[0];
            void'(modelQ.pop_front());
         end
         if (wAcc) begin
            modelQ.push_back(din);
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model, on the
   // falling edge so inputs and registered outputs are stable.
   always @(negedge CLK) begin
      int size;
      logic [WIDTH-1:0] expHead;
      if (checkEn) begin
         size    = modelQ.size();
         expHead = (size > 0) ? modelQ[0] : INIT;
         checkOutput("fwft DOUT",       32'(fDout),      32'(expHead));
         checkOutput("std DOUT",        32'(sDout),      32'(modelStdDout));
         checkOutput("fwft DATA_COUNT", 32'(fCount),     32'(size));
         checkOutput("std DATA_COUNT",  32'(sCount),     32'(size));
         checkOutput("fwft FULL",       32'(fFull),      32'(size == DEPTH));
         checkOutput("std FULL",        32'(sFull),      32'(size == DEPTH));
         checkOutput("fwft NOT_EMPTY",  32'(fNotEmpty),  32'(size > 0));
         checkOutput("std NOT_EMPTY",   32'(sNotEmpty),  32'(size > 0));
         checkOutput("fwft PROG_FULL",  32'(fProgFull),  32'(size >= int'(progFullThre)));
         checkOutput("std PROG_FULL",   32'(sProgFull),  32'(size >= int'(progFullThre)));
         checkOutput("fwft PROG_EMPTY", 32'(fProgEmpty), 32'(size <= int'(progEmptyThre)));
         checkOutput("std PROG_EMPTY",  32'(sProgEmpty), 32'(size <= int'(progEmptyThre)));
         checkOutput("fwft OVERFLOW",   32'(fOvf),       32'(modelOvf));
         checkOutput("std OVERFLOW",    32'(sOvf),       32'(modelOvf));
         checkOutput("fwft UNDERFLOW",  32'(fUdf),       32'(modelUdf));
         checkOutput("std UNDERFLOW",   32'(sUdf),       32'(modelUdf));
      end
   end

   initial begin
      RESET         = 1'b1;
      we            = 1'b0;
      re            = 1'b0;
      din           = '0;
      progFullThre  = 6'd30;
      progEmptyThre = 6'd2;

      // Reset, then idle.
      applyStimulus(1, 0, 0, 16'h0);
      applyStimulus(1, 0, 0, 16'h0);
      checkEn = 1'b1;
      applyStimulus(0, 0, 0, 16'h0);
      checkOutput("reset fwft DOUT",   32'(fDout),      32'hFFFF);
      checkOutput("reset std DOUT",    32'(sDout),      32'hFFFF);
      checkOutput("reset NOT_EMPTY",   32'(fNotEmpty),  32'd0);
      checkOutput("reset PROG_EMPTY",  32'(fProgEmpty), 32'd1);
      checkOutput("reset DATA_COUNT",  32'(fCount),     32'd0);

      // Fill with 0x0001..0x0020; FULL only after the 32nd write.
      for (int i = 1; i <= 32; i++) begin
         applyStimulus(0, 1, 0, 16'(i));
         if (i == 31) checkOutput("not full at 31", 32'(fFull), 32'd0);
      end
      checkOutput("full at 32",        32'(fFull),  32'd1);
      checkOutput("count at 32",       32'(fCount), 32'd32);
      checkOutput("fwft head after fill", 32'(fDout), 32'h0001);

      // 33rd write is rejected.
      applyStimulus(0, 1, 0, 16'h0021);
      checkOutput("overflow pulse",    32'(fOvf),   32'd1);
      checkOutput("count after ovf",   32'(fCount), 32'd32);

      // Read everything back in order.
      for (int i = 1; i <= 32; i++) begin
         checkOutput("fwft readback", 32'(fDout), 32'(i));
         applyStimulus(0, 0, 1, 16'h0);
         checkOutput("std readback",  32'(sDout), 32'(i));
      end
      checkOutput("empty after drain", 32'(fNotEmpty), 32'd0);

      // Read on empty: underflow, standard output holds.
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("underflow pulse",   32'(sUdf),  32'd1);
      checkOutput("std hold on udf",   32'(sDout), 32'h0020);
      checkOutput("fwft init on empty", 32'(fDout), 32'hFFFF);

      // Standard read latency with a single word.
      applyStimulus(0, 1, 0, 16'hA5A5);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("std A5A5",          32'(sDout), 32'hA5A5);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("std A5A5 udf",      32'(sUdf),  32'd1);
      checkOutput("std A5A5 hold",     32'(sDout), 32'hA5A5);

      // Fill, then hammer write+read across pointer wrap.
      for (int i = 0; i < 32; i++) applyStimulus(0, 1, 0, 16'(16'h0100 + i));
      for (int i = 0; i < 64; i++) begin
         applyStimulus(0, 1, 1, 16'(16'h0200 + i));
         if (i == 0) begin
            checkOutput("wrap count first", 32'(fCount), 32'd31);
            checkOutput("wrap ovf first",   32'(fOvf),   32'd1);
         end
         if (i == 1) checkOutput("wrap count second", 32'(fCount), 32'd31);
      end
      checkOutput("wrap fwft head", 32'(fDout), 32'h0221);

      // Drain the 31 remaining words.
      for (int i = 0; i < 31; i++) applyStimulus(0, 0, 1, 16'h0);
      checkOutput("empty after wrap", 32'(fCount), 32'd0);

      // Runtime thresholds at count 4.
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'(16'h0300 + i));
      we = 1'b0;
      progFullThre = 6'd5;
      #1;
      checkOutput("prog full thre 5", 32'(fProgFull), 32'd0);
      progFullThre = 6'd3;
      #1;
      checkOutput("prog full thre 3", 32'(fProgFull), 32'd1);
      checkOutput("prog empty thre 2", 32'(fProgEmpty), 32'd0);
      progEmptyThre = 6'd4;
      #1;
      checkOutput("prog empty thre 4", 32'(fProgEmpty), 32'd1);

      // Reset with 10 entries stored.
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 16'(16'h0400 + i));
      checkOutput("count 10", 32'(fCount), 32'd10);
      applyStimulus(1, 0, 0, 16'h0);
      checkOutput("mid reset count",     32'(fCount),    32'd0);
      checkOutput("mid reset NOT_EMPTY", 32'(fNotEmpty), 32'd0);
      checkOutput("mid reset fwft DOUT", 32'(fDout),     32'hFFFF);
      checkOutput("mid reset std DOUT",  32'(sDout),     32'hFFFF);
      applyStimulus(0, 1, 0, 16'h0BEE);
      checkOutput("post reset fwft", 32'(fDout), 32'h0BEE);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("post reset std",  32'(sDout), 32'h0BEE);

      // Mixed traffic checked by the model only.
      progFullThre  = 6'd20;
      progEmptyThre = 6'd6;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 16'hFFFF)));
      end
      applyStimulus(0, 0, 0, 16'h0);

      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Second-generation single-clock FIFO for the acquisition data paths. It stores the full DEPTH entries and supports two read modes: first-word-fall-through and standard registered read. It adds an exact occupancy count, runtime-programmable almost-full/almost-empty thresholds, and sticky-free overflow/underflow error pulses. It sits between the ADC framing logic and downstream packetisers, replacing the fixed-threshold FIFO.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 32, storage entries; power of two, >=4; all DEPTH entries usable
FWFT, 1, 1 = first-word-fall-through read, 0 = standard read with 1-cycle latency
INIT_VALUE, {WIDTH{1'b1}}, DOUT value after reset and whenever no valid word is presented
CW (derived), clogb2(DEPTH)+1, count/threshold width

Ports:
CLK  in  1  single clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
DIN  in  WIDTH  write data
WE  in  1  write request
FULL  out  1  DEPTH entries stored
DOUT  out  WIDTH  read data
RE  in  1  read request/pop
NOT_EMPTY  out  1  >=1 entry stored
DATA_COUNT  out  CW  entries stored, 0..DEPTH
PROG_FULL_THRE  in  CW  almost-full threshold (runtime)
PROG_EMPTY_THRE  in  CW  almost-empty threshold (runtime)
PROGRAMMABLE_FULL  out  1  DATA_COUNT >= PROG_FULL_THRE
PROGRAMMABLE_EMPTY  out  1  DATA_COUNT <= PROG_EMPTY_THRE
OVERFLOW  out  1  1-cycle pulse: write rejected
UNDERFLOW  out  1  1-cycle pulse: read rejected

Behaviour:
- Reset (RESET=1 at edge): pointers=0, count=0, FULL=0, NOT_EMPTY=0, OVERFLOW=UNDERFLOW=0, DOUT=INIT_VALUE. Storage array is not reset (RAM inference). Reset mid-operation discards all contents in one cycle.
- Pointers are CW bits wide and wrap naturally mod 2*DEPTH. Address = low CW-1 bits. Empty when wp==rp. Full when MSBs differ and the low bits are equal.
- FULL, NOT_EMPTY, and DATA_COUNT are registered and exact the cycle after the causing edge. No one-entry-early full.
- Write accepted iff WE && !FULL. WE && FULL -> no write, OVERFLOW=1 the next cycle.
- Read accepted iff RE && NOT_EMPTY. RE && !NOT_EMPTY -> UNDERFLOW=1 the next cycle.
- Simultaneous accepted read and write: both occur and DATA_COUNT is unchanged.
  - When full: the read is accepted and the write rejected (OVERFLOW).
  - When empty: the write is accepted and the read rejected (UNDERFLOW).
- Count update: +1 on write only, -1 on read only. PROGRAMMABLE_* flags are combinational compares of registered DATA_COUNT against the live threshold inputs (unsigned, CW bits).
- FWFT=1:
  - DOUT = mem[rp] while NOT_EMPTY, else INIT_VALUE.
  - A write into an empty FIFO makes NOT_EMPTY and the word visible 1 cycle after the write edge.
  - RE pops the head word; the next word is visible after that edge.
- FWFT=0:
  - DOUT is registered. An accepted read loads mem[rp] into DOUT at that edge (visible the next cycle).
  - DOUT holds its value otherwise, including across rejected reads.
- No X on any output after reset regardless of WE/RE activity.

Decomposition:
- Shared package fifo_pkg:
  - clogb2 function
  - FIFO_MODE_STD=0, FIFO_MODE_FWFT=1 constants
  - count-width helper
- One sub-module, sdp_ram:
  - parameters WIDTH, DEPTH
  - one write port, one asynchronous-read port
  - no reset
- Pointer, flag, and count logic plus the mode-dependent output stage live in sync_fifo_fwft.

Test Plan:
- Reset then idle, FWFT=1, DEPTH=32: DOUT=all ones, NOT_EMPTY=0, PROGRAMMABLE_EMPTY=1 (EMPTY_THRE=2), DATA_COUNT=0.
- Write 0x0001..0x0020 (32 words): FULL=1 exactly after the 32nd write, DATA_COUNT=32. The 33rd WE gives OVERFLOW pulse, and the contents read back 0x0001..0x0020 in order.
- FWFT=0, write 0xA5A5 then RE: DOUT=0xA5A5 one cycle after the RE edge. A second RE on empty gives UNDERFLOW pulse and DOUT holds 0xA5A5.
- Full FIFO, WE+RE for 64 cycles with incrementing data: DATA_COUNT oscillates 32→31→31…. Every write on a full cycle is rejected and the read stream stays strictly ordered across pointer wrap.
- Runtime thresholds FULL_THRE=5 then 3 with count=4: PROGRAMMABLE_FULL goes 0→1 in the same cycle the threshold changes.
- RESET asserted with 10 entries stored: next cycle DATA_COUNT=0, NOT_EMPTY=0, DOUT=INIT_VALUE. The next write/read returns the new data, not stale data.
